// File: rtl/forward_if.sv
// Bundles the EX/MEM/WB forwarding inputs and the select/monitor outputs
// of the forwarding unit. The master side drives the pipeline addresses and
// write flags; the slave side (the forwarding unit) returns selects and counters.
interface forward_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       RA1_EX;
    logic [3:0]       RA2_EX;
    logic [3:0]       RA1_MEM;
    logic [3:0]       RA1_WB;
    logic             R0W;
    logic             RegWrite_MEM;
    logic             RegWrite_WB;
    logic             cnt_en;
    logic [1:0]       FWD1;
    logic [1:0]       FWD2;
    logic [1:0]       FWD1_q;
    logic [1:0]       FWD2_q;
    logic [CNT_W-1:0] fwd_mem_cnt;
    logic [CNT_W-1:0] fwd_wb_cnt;
    logic [CNT_W-1:0] fwd_r0_cnt;

    modport master (
        output RA1_EX, RA2_EX, RA1_MEM, RA1_WB,
        output R0W, RegWrite_MEM, RegWrite_WB, cnt_en,
        input  FWD1, FWD2, FWD1_q, FWD2_q,
        input  fwd_mem_cnt, fwd_wb_cnt, fwd_r0_cnt
    );

    modport slave (
        input  RA1_EX, RA2_EX, RA1_MEM, RA1_WB,
        input  R0W, RegWrite_MEM, RegWrite_WB, cnt_en,
        output FWD1, FWD2, FWD1_q, FWD2_q,
        output fwd_mem_cnt, fwd_wb_cnt, fwd_r0_cnt
    );
endinterface

// File: rtl/forward.sv
// EX-stage operand forwarding unit.
// Selects: 00 register file, 01 MEM result, 10 WB result, 11 WB R0-port value.
// The selects are combinational; a registered copy and three saturating
// event counters are kept for debug/performance monitoring.
module forward #(
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    forward_if.slave bus
);

    logic [1:0]       w_fwd1;
    logic [1:0]       w_fwd2;
    logic [1:0]       w_n_mem;
    logic [1:0]       w_n_wb;
    logic [1:0]       w_n_r0;

    logic [1:0]       r_fwd1_q;
    logic [1:0]       r_fwd2_q;
    logic [CNT_W-1:0] r_mem_cnt;
    logic [CNT_W-1:0] r_wb_cnt;
    logic [CNT_W-1:0] r_r0_cnt;

    // MEM is the newest producer so it is checked first; the R0 port only
    // applies to address 0, and register 0 is otherwise an ordinary register.
    function automatic logic [1:0] f_sel(
        input logic [3:0] ra,
        input logic [3:0] ra_mem,
        input logic [3:0] ra_wb,
        input logic       r0w,
        input logic       we_mem,
        input logic       we_wb
    );
        if (we_mem && (ra_mem == ra))
            return 2'b01;
        else if (r0w && (ra == 4'd0))
            return 2'b11;
        else if (we_wb && (ra_wb == ra))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Add 0..2 with clamping at all-ones; the extra sum bit catches overflow
    // even when the increment of 2 starts one below the maximum.
    function automatic logic [CNT_W-1:0] f_sat_add(
        input logic [CNT_W-1:0] cnt,
        input logic [1:0]       inc
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // Operand selects and per-source event counts for this cycle.
    always_comb begin
        w_fwd1  = f_sel(bus.RA1_EX, bus.RA1_MEM, bus.RA1_WB,
                        bus.R0W, bus.RegWrite_MEM, bus.RegWrite_WB);
        w_fwd2  = f_sel(bus.RA2_EX, bus.RA1_MEM, bus.RA1_WB,
                        bus.R0W, bus.RegWrite_MEM, bus.RegWrite_WB);
        w_n_mem = 2'(w_fwd1 == 2'b01) + 2'(w_fwd2 == 2'b01);
        w_n_wb  = 2'(w_fwd1 == 2'b10) + 2'(w_fwd2 == 2'b10);
        w_n_r0  = 2'(w_fwd1 == 2'b11) + 2'(w_fwd2 == 2'b11);
    end

    // Capture selects and accumulate counts only while the pipeline advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd1_q  <= 2'b00;
            r_fwd2_q  <= 2'b00;
            r_mem_cnt <= '0;
            r_wb_cnt  <= '0;
            r_r0_cnt  <= '0;
        end else if (bus.cnt_en) begin
            r_fwd1_q  <= w_fwd1;
            r_fwd2_q  <= w_fwd2;
            r_mem_cnt <= f_sat_add(r_mem_cnt, w_n_mem);
            r_wb_cnt  <= f_sat_add(r_wb_cnt, w_n_wb);
            r_r0_cnt  <= f_sat_add(r_r0_cnt, w_n_r0);
        end
    end

    assign bus.FWD1        = w_fwd1;
    assign bus.FWD2        = w_fwd2;
    assign bus.FWD1_q      = r_fwd1_q;
    assign bus.FWD2_q      = r_fwd2_q;
    assign bus.fwd_mem_cnt = r_mem_cnt;
    assign bus.fwd_wb_cnt  = r_wb_cnt;
    assign bus.fwd_r0_cnt  = r_r0_cnt;

endmodule

// File: tb/tb_forward.sv
// Bench for the forwarding unit: a 16-bit-counter instance and a 2-bit-counter
// instance share the same stimulus; a scoreboard queue carries expected values
// from the stimulus side to a negedge monitor.
module tb_forward;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ra1_ex, ra2_ex, ra1_mem, ra1_wb;
    logic       r0w, rw_mem, rw_wb, cnt_en;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    forward_if #(.CNT_W(16)) if16 ();
    forward_if #(.CNT_W(2))  if2 ();

    assign if16.RA1_EX = ra1_ex;  assign if2.RA1_EX = ra1_ex;
    assign if16.RA2_EX = ra2_ex;  assign if2.RA2_EX = ra2_ex;
    assign if16.RA1_MEM = ra1_mem; assign if2.RA1_MEM = ra1_mem;
    assign if16.RA1_WB = ra1_wb;  assign if2.RA1_WB = ra1_wb;
    assign if16.R0W = r0w;        assign if2.R0W = r0w;
    assign if16.RegWrite_MEM = rw_mem; assign if2.RegWrite_MEM = rw_mem;
    assign if16.RegWrite_WB = rw_wb;   assign if2.RegWrite_WB = rw_wb;
    assign if16.cnt_en = cnt_en;  assign if2.cnt_en = cnt_en;

    forward #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    forward #(.CNT_W(2))  dut2  (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        int f1, f2, q1, q2;
        int c16[3];
        int c2[3];
    } exp_t;

    exp_t sb[$];

    // reference state: registered selects and per-source counts (index 0 MEM, 1 WB, 2 R0)
    int m_q1, m_q2;
    int mc16[3];
    int mc2[3];

    // behavioural selection rule, operand by operand
    function automatic int ref_sel(input int ra, input int am, input int aw,
                                   input bit r0, input bit wm, input bit ww);
        if (wm && am == ra) return 1;
        if (r0 && ra == 0)  return 3;
        if (ww && aw == ra) return 2;
        return 0;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q1 = 0; m_q2 = 0;
        for (int k = 0; k < 3; k++) begin mc16[k] = 0; mc2[k] = 0; end
    endtask

    // One cycle: advance the model across the edge just taken, apply new inputs, queue expectations.
    task automatic step(input int a1, input int a2, input int am, input int aw,
                        input bit r0, input bit wm, input bit ww, input bit en, input bit r);
        int s1, s2, n;
        exp_t e;
        @(posedge clk); #1;
        if (!rst && cnt_en) begin
            s1 = ref_sel(ra1_ex, ra1_mem, ra1_wb, r0w, rw_mem, rw_wb);
            s2 = ref_sel(ra2_ex, ra1_mem, ra1_wb, r0w, rw_mem, rw_wb);
            m_q1 = s1; m_q2 = s2;
            for (int k = 0; k < 3; k++) begin
                n = ((s1 == k + 1) ? 1 : 0) + ((s2 == k + 1) ? 1 : 0);
                mc16[k] = imin(mc16[k] + n, 65535);
                mc2[k]  = imin(mc2[k] + n, 3);
            end
        end
        ra1_ex = 4'(a1); ra2_ex = 4'(a2); ra1_mem = 4'(am); ra1_wb = 4'(aw);
        r0w = r0; rw_mem = wm; rw_wb = ww; cnt_en = en; rst = r;
        if (r) model_clear();
        e.f1 = ref_sel(a1, am, aw, r0, wm, ww);
        e.f2 = ref_sel(a2, am, aw, r0, wm, ww);
        e.q1 = m_q1; e.q2 = m_q2;
        for (int k = 0; k < 3; k++) begin e.c16[k] = mc16[k]; e.c2[k] = mc2[k]; end
        sb.push_back(e);
    endtask

    // directed case with hand-derived select values
    task automatic tp(input int a1, input int a2, input int am, input int aw,
                      input bit r0, input bit wm, input bit ww, input int e1, input int e2);
        step(a1, a2, am, aw, r0, wm, ww, 1'b1, 1'b0);
        @(negedge clk);
        chk("tp_FWD1", int'(if16.FWD1), e1);
        chk("tp_FWD2", int'(if16.FWD2), e2);
    endtask

    // scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("FWD1", int'(if16.FWD1), e.f1);
                chk("FWD2", int'(if16.FWD2), e.f2);
                chk("FWD1_q", int'(if16.FWD1_q), e.q1);
                chk("FWD2_q", int'(if16.FWD2_q), e.q2);
                chk("mem_cnt16", int'(if16.fwd_mem_cnt), e.c16[0]);
                chk("wb_cnt16", int'(if16.fwd_wb_cnt), e.c16[1]);
                chk("r0_cnt16", int'(if16.fwd_r0_cnt), e.c16[2]);
                chk("mem_cnt2", int'(if2.fwd_mem_cnt), e.c2[0]);
                chk("wb_cnt2", int'(if2.fwd_wb_cnt), e.c2[1]);
                chk("r0_cnt2", int'(if2.fwd_r0_cnt), e.c2[2]);
                chk("FWD1_w2", int'(if2.FWD1), e.f1);
                chk("FWD2_q_w2", int'(if2.FWD2_q), e.q2);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[4];
        seq[0] = 0; seq[1] = 2; seq[2] = 3; seq[3] = 3;
        rst = 1'b1; cnt_en = 1'b0;
        ra1_ex = '0; ra2_ex = '0; ra1_mem = '0; ra1_wb = '0;
        r0w = 1'b0; rw_mem = 1'b0; rw_wb = 1'b0;
        model_clear();

        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("rst_mem_cnt", int'(if16.fwd_mem_cnt), 0);
        chk("rst_FWD1_q", int'(if16.FWD1_q), 0);

        // directed selection cases
        tp(5, 0, 5, 0, 0, 1, 0, 1, 0);
        tp(2, 0, 0, 2, 0, 0, 1, 2, 0);
        tp(0, 2, 0, 2, 1, 0, 0, 3, 0);
        tp(0, 8, 8, 0, 0, 1, 0, 0, 1);
        tp(0, 8, 0, 8, 0, 0, 1, 0, 2);
        tp(2, 0, 0, 8, 1, 0, 0, 0, 3);
        tp(6, 7, 6, 7, 1, 1, 1, 1, 2);
        tp(3, 3, 3, 3, 0, 1, 1, 1, 1);
        tp(0, 5, 9, 0, 1, 0, 1, 3, 0);
        tp(0, 0, 0, 0, 0, 1, 0, 1, 1);
        tp(4, 4, 0, 0, 1, 0, 0, 0, 0);
        tp(4, 4, 4, 4, 0, 0, 0, 0, 0);
        tp(0, 0, 0, 0, 0, 0, 1, 2, 2);

        // hold 6/7 for three counted cycles
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(6, 7, 6, 7, 1, 1, 1, 1, 0);
        step(6, 7, 6, 7, 1, 1, 1, 0, 0);
        @(negedge clk);
        chk("hold_mem_cnt", int'(if16.fwd_mem_cnt), 3);
        chk("hold_wb_cnt", int'(if16.fwd_wb_cnt), 3);
        chk("hold_r0_cnt", int'(if16.fwd_r0_cnt), 0);
        chk("hold_FWD1_q", int'(if16.FWD1_q), 1);
        chk("hold_FWD2_q", int'(if16.FWD2_q), 2);

        // cnt_en low with active forwards: registered side frozen, selects live
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(3, 3, 3, 0, 0, 1, 0, 0, 0);
        step(9, 1, 0, 1, 0, 0, 1, 0, 0);
        step(2, 0, 2, 5, 1, 1, 1, 0, 0);
        @(negedge clk);
        chk("frz_FWD1", int'(if16.FWD1), 1);
        chk("frz_FWD2", int'(if16.FWD2), 3);
        chk("frz_mem_cnt", int'(if16.fwd_mem_cnt), 3);
        chk("frz_FWD1_q", int'(if16.FWD1_q), 1);

        // async reset mid-cycle
        step(6, 7, 6, 7, 1, 1, 1, 1, 1);
        #2;
        chk("async_mem_cnt", int'(if16.fwd_mem_cnt), 0);
        chk("async_wb_cnt", int'(if16.fwd_wb_cnt), 0);
        chk("async_FWD2_q", int'(if16.FWD2_q), 0);
        chk("async_FWD1_live", int'(if16.FWD1), 1);

        // 2-bit counter saturation with a dual MEM forward
        for (int i = 0; i < 4; i++) begin
            step(4, 4, 4, 0, 0, 1, 0, 1, 0);
            @(negedge clk);
            chk("sat2_seq", int'(if2.fwd_mem_cnt), seq[i]);
        end

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            int a1, a2, am, aw;
            bit wide;
            wide = ($urandom_range(0, 3) == 0);
            a1 = wide ? $urandom_range(0, 15) : $urandom_range(0, 3);
            a2 = wide ? $urandom_range(0, 15) : $urandom_range(0, 3);
            am = wide ? $urandom_range(0, 15) : $urandom_range(0, 3);
            aw = wide ? $urandom_range(0, 15) : $urandom_range(0, 3);
            step(a1, a2, am, aw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 59) == 0));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/forward.md
Name: forward

Overview:
- Operand-forwarding (bypass) control unit for the 4-bit-register-address pipeline.
- Sits in the EX stage. Compares the EX-stage source register addresses against the destination addresses of the MEM and WB stages, including the dedicated WB-stage R0 write.
- Produces combinational 2-bit mux selects, FWD1 and FWD2, for the two ALU operand muxes.
- Also keeps registered copies of the selects and saturating forwarding-event counters for debug and performance monitoring.

Parameters:
- CNT_W, 16, width of each forwarding-event counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- RA1_EX  input  4  first source register address of the instruction in EX.
- RA2_EX  input  4  second source register address of the instruction in EX.
- RA1_MEM  input  4  destination register address of the instruction in MEM.
- RA1_WB  input  4  destination register address of the instruction in WB.
- R0W  input  1  the WB-stage instruction writes R0 through the dedicated R0 write port.
- RegWrite_MEM  input  1  the MEM-stage instruction writes RA1_MEM.
- RegWrite_WB  input  1  the WB-stage instruction writes RA1_WB.
- cnt_en  input  1  counter/capture enable (pipeline advancing this cycle).
- FWD1  output  2  operand-1 select (combinational).
- FWD2  output  2  operand-2 select (combinational).
- FWD1_q  output  2  FWD1 registered on clk.
- FWD2_q  output  2  FWD2 registered on clk.
- fwd_mem_cnt  output  CNT_W  count of operands forwarded from MEM.
- fwd_wb_cnt  output  CNT_W  count of operands forwarded from the WB general port.
- fwd_r0_cnt  output  CNT_W  count of operands forwarded from the WB R0 port.

Behaviour:
- Select encoding:
  - 2'b00 = register-file value (no forward).
  - 2'b01 = MEM-stage result.
  - 2'b10 = WB-stage result.
  - 2'b11 = WB-stage R0 write value.
- FWD1 and FWD2 are purely combinational, with zero latency, and are evaluated independently. The same priority applies to each operand, with RAx_EX standing for RA1_EX or RA2_EX:
  1. RegWrite_MEM && RA1_MEM == RAx_EX → 01. The newest producer wins.
  2. Else R0W && RAx_EX == 0 → 11.
  3. Else RegWrite_WB && RA1_WB == RAx_EX → 10.
  4. Else → 00.
- Register 0 is an ordinary architectural register. Matches on address 0 through the MEM or WB general paths forward normally. There is no zero-register suppression.
- R0W is ignored for any operand whose address is non-zero.
- Address matches are ignored when the corresponding RegWrite signal is 0.
- Both operands may forward simultaneously, from the same or different sources.
- Registered copies:
  - On each rising clk edge with cnt_en = 1: FWD1_q <= FWD1 and FWD2_q <= FWD2.
  - When cnt_en = 0, FWD1_q and FWD2_q hold their values.
- Counters:
  - On each rising clk edge with cnt_en = 1, each counter adds the number of operands (0, 1 or 2) whose select equals its source: 01 for fwd_mem_cnt, 10 for fwd_wb_cnt, 11 for fwd_r0_cnt.
  - Counters saturate at all-ones. No wrap-around; an increment of 2 from all-ones minus 1 also clamps to all-ones.
- Reset:
  - rst = 1 asynchronously forces FWD1_q, FWD2_q and all counters to 0, overriding clk and cnt_en.
  - FWD1 and FWD2 remain combinational functions of the inputs during reset.
  - Deassertion takes effect at the next rising clk edge.
- Unknown or X inputs are out of scope; all inputs are assumed driven.

Test Plan:
- RA1_EX=5, RA2_EX=0, RA1_MEM=5, RA1_WB=0, R0W=0, RegWrite_MEM=1, RegWrite_WB=0 → FWD1=01, FWD2=00.
- RA1_EX=2, RA2_EX=0, RA1_WB=2, RegWrite_WB=1, RegWrite_MEM=0, R0W=0 → FWD1=10, FWD2=00. Then RA1_EX=0, RA2_EX=2, R0W=1, both RegWrite=0 → FWD1=11, FWD2=00.
- RA1_EX=0, RA2_EX=8, RA1_MEM=8, RegWrite_MEM=1, R0W=0 → FWD1=00, FWD2=01. Then RA1_MEM=0, RA1_WB=8, RegWrite_MEM=0, RegWrite_WB=1 → FWD1=00, FWD2=10. Then RA1_EX=2, RA2_EX=0, R0W=1, both RegWrite=0 → FWD1=00, FWD2=11.
- Both operands and priority:
  - RA1_EX=6, RA2_EX=7, RA1_MEM=6, RA1_WB=7, R0W=1, both RegWrite=1 → FWD1=01, FWD2=10.
  - RA1_EX=RA1_MEM=RA1_WB=3, both RegWrite=1 → FWD1=01 (MEM beats WB).
  - RA1_EX=0, RA1_WB=0, RegWrite_WB=1, R0W=1, RegWrite_MEM=0 → FWD1=11.
- Counters and reset:
  - Hold the 6/7 case with cnt_en=1 for 3 cycles → fwd_mem_cnt=3, fwd_wb_cnt=3, fwd_r0_cnt=0, FWD1_q=01.
  - Pulse rst mid-cycle → all registered outputs read 0 immediately.
  - With CNT_W=2, holding a dual-MEM forward → counter sequence 0, 2, 3, 3.
- cnt_en=0 with active forwards for 4 cycles → counters and FWD1_q/FWD2_q unchanged, while FWD1/FWD2 still track the inputs.
